// File: rtl/mb_clk_phase_tracker.sv
`default_nettype none
// ============================================================================
// Module   : mb_clk_phase_tracker
// Purpose  : Synchronises the motherboard bus clock, measures its period,
//            declares lock and predicts the next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module mb_clk_phase_tracker #(
    parameter int MIN_PERIOD = 12,
    parameter int MAX_PERIOD = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 32,
    parameter int PRE_RISE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mb_clk_i,
    output logic       mb_clk_s,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic [7:0] phase,
    output logic [7:0] period,
    output logic       locked,
    output logic       pre_rise_stb,
    output logic       lost_stb
);

    localparam logic [7:0] c_min_period = 8'(MIN_PERIOD);
    localparam logic [7:0] c_max_period = 8'(MAX_PERIOD);
    localparam logic [7:0] c_timeout    = 8'(TIMEOUT);
    localparam logic [3:0] c_lock_count = 4'(LOCK_COUNT);
    localparam logic [8:0] c_pre_rise   = 9'(PRE_RISE);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_good_cnt;
    logic [3:0] w_good_next;
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic       w_rise_next;
    logic       w_in_window;
    logic       w_timeout;
    logic       w_pre_hit;
    logic [7:0] w_phase_next;
    logic [7:0] w_phase_inc;

    assign mb_clk_s = r_s2;

    // A rising edge on the synchronised clock: rise_stb asserts on the next edge.
    assign w_rise_next  = r_s2 & ~r_s3;
    assign w_phase_inc  = (phase == 8'hFF) ? 8'hFF : phase + 8'd1;
    assign w_phase_next = w_rise_next ? 8'd0 : w_phase_inc;
    assign w_in_window  = (period >= c_min_period) && (period <= c_max_period);

    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        w_timeout    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (rise_stb) begin
                    w_state_next = ST_CHECK;
                    w_good_next  = 4'd0;
                end
            end
            ST_CHECK: begin
                if (rise_stb) begin
                    if (w_in_window) begin
                        w_good_next = r_good_cnt + 4'd1;
                        if (r_good_cnt + 4'd1 == c_lock_count) begin
                            w_state_next = ST_LOCKED;
                        end
                    end else begin
                        w_good_next = 4'd0;
                    end
                end else if ((phase == c_timeout) && !w_rise_next) begin
                    w_state_next = ST_SEARCH;
                    w_good_next  = 4'd0;
                    w_timeout    = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (rise_stb) begin
                    if (!w_in_window) begin
                        w_state_next = ST_CHECK;
                        w_good_next  = 4'd0;
                    end
                end else if ((phase == c_timeout) && !w_rise_next) begin
                    w_state_next = ST_SEARCH;
                    w_good_next  = 4'd0;
                    w_timeout    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_good_next  = 4'd0;
            end
        endcase
    end

    // Registered prediction: evaluated on next-cycle phase so the strobe lands at period - PRE_RISE.
    assign w_pre_hit = (w_state_next == ST_LOCKED) &&
                       ({1'b0, w_phase_next} + c_pre_rise == {1'b0, period});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            rise_stb     <= 1'b0;
            fall_stb     <= 1'b0;
            phase        <= 8'd0;
            period       <= 8'd0;
            r_state      <= ST_SEARCH;
            r_good_cnt   <= 4'd0;
            locked       <= 1'b0;
            pre_rise_stb <= 1'b0;
            lost_stb     <= 1'b0;
        end else begin
            r_s1         <= mb_clk_i;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            rise_stb     <= r_s2 & ~r_s3;
            fall_stb     <= ~r_s2 & r_s3;
            phase        <= w_phase_next;
            // The first rise after SEARCH has no reference edge, so no period.
            if (w_rise_next && (r_state != ST_SEARCH)) begin
                period <= w_phase_inc;
            end
            r_state      <= w_state_next;
            r_good_cnt   <= w_good_next;
            locked       <= (w_state_next == ST_LOCKED);
            pre_rise_stb <= w_pre_hit;
            lost_stb     <= w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mb_clk_phase_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_clk_phase_tracker
// Purpose  : Self-checking bench for mb_clk_phase_tracker against an
//            event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mb_clk_phase_tracker;

    localparam int MIN_P  = 12;
    localparam int MAX_P  = 16;
    localparam int LOCK_N = 4;
    localparam int TMO    = 32;
    localparam int PRE    = 3;

    localparam int M_SEARCH = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mb_clk_i = 1'b0;
    logic       mb_clk_s;
    logic       rise_stb;
    logic       fall_stb;
    logic [7:0] phase;
    logic [7:0] period;
    logic       locked;
    logic       pre_rise_stb;
    logic       lost_stb;

    always #5 clk = ~clk;

    mb_clk_phase_tracker #(
        .MIN_PERIOD (MIN_P),
        .MAX_PERIOD (MAX_P),
        .LOCK_COUNT (LOCK_N),
        .TIMEOUT    (TMO),
        .PRE_RISE   (PRE)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .mb_clk_i     (mb_clk_i),
        .mb_clk_s     (mb_clk_s),
        .rise_stb     (rise_stb),
        .fall_stb     (fall_stb),
        .phase        (phase),
        .period       (period),
        .locked       (locked),
        .pre_rise_stb (pre_rise_stb),
        .lost_stb     (lost_stb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: edges are detected from the sample history, periods are
    // the distance in cycles between consecutive rises, lock follows the rise list.
    bit q_samp [3];
    int m_phase, m_period, m_state, m_good, last_rise, cyc;
    bit m_rise, m_fall, m_s2, m_lost, m_pre, have_ref, started;
    bit rise_now, fall_now, p_rise;
    int p_phase, p_period;

    function automatic bit in_win(input int p);
        return (p >= MIN_P) && (p <= MAX_P);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            q_samp   = '{0, 0, 0};
            m_phase  = 0;  m_period = 0;  m_state = M_SEARCH;  m_good = 0;
            m_rise   = 0;  m_fall = 0;  m_s2 = 0;  m_lost = 0;  m_pre = 0;
            have_ref = 0;  started = 1;
        end else begin
            rise_now = q_samp[1] && !q_samp[2];
            fall_now = !q_samp[1] && q_samp[2];
            q_samp[2] = q_samp[1];
            q_samp[1] = q_samp[0];
            q_samp[0] = mb_clk_i;
            p_rise = m_rise;  p_phase = m_phase;  p_period = m_period;
            m_lost = 0;
            if (p_rise) begin
                if (m_state == M_SEARCH) begin
                    m_state = M_CHECK;  m_good = 0;
                end else if (!in_win(p_period)) begin
                    m_state = M_CHECK;  m_good = 0;
                end else if (m_state == M_CHECK) begin
                    m_good++;
                    if (m_good == LOCK_N) m_state = M_LOCKED;
                end
            end else if (m_state != M_SEARCH && p_phase == TMO && !rise_now) begin
                m_state = M_SEARCH;  m_good = 0;  m_lost = 1;  have_ref = 0;
            end
            if (rise_now) begin
                if (have_ref) m_period = (cyc - last_rise > 255) ? 255 : cyc - last_rise;
                last_rise = cyc;
                have_ref  = 1;
                m_phase   = 0;
            end else begin
                m_phase = (m_phase >= 255) ? 255 : m_phase + 1;
            end
            m_rise = rise_now;
            m_fall = fall_now;
            m_s2   = q_samp[1];
            m_pre  = (m_state == M_LOCKED) && (m_phase == m_period - PRE);
        end
    end

    int lost_seen = 0;

    always @(negedge clk) begin
        if (started) begin
            check_val("mb_clk_s", mb_clk_s, m_s2);
            check_val("rise_stb", rise_stb, m_rise);
            check_val("fall_stb", fall_stb, m_fall);
            check_val("phase", phase, m_phase);
            check_val("period", period, m_period);
            check_val("locked", locked, m_state == M_LOCKED);
            check_val("pre_rise_stb", pre_rise_stb, m_pre);
            check_val("lost_stb", lost_stb, m_lost);
            if (lost_stb) lost_seen++;
        end
    end

    task automatic drive_periods(input int p, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            mb_clk_i = 1'b1;
            repeat (hi) @(negedge clk);
            mb_clk_i = 1'b0;
            repeat (p - hi) @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int l0;

    initial begin
        @(negedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("reset_phase", phase, 0);
        check_val("reset_locked", locked, 0);

        // Steady 14-cycle clock: lock comes with the 5th rise
        drive_periods(14, 7, 4);
        check_val("lock14_after4", locked, 0);
        drive_periods(14, 7, 1);
        check_val("lock14_after5", locked, 1);
        drive_periods(14, 7, 3);
        check_val("lock14_period", period, 14);

        // Out-of-window clock
        drive_periods(20, 10, 8);
        check_val("p20_locked", locked, 0);
        check_val("p20_period", period, 20);

        // Clock loss and recovery
        drive_periods(14, 7, 8);
        check_val("preloss_locked", locked, 1);
        l0 = lost_seen;
        repeat (60) @(negedge clk);
        check_val("loss_count", lost_seen - l0, 1);
        check_val("loss_locked", locked, 0);
        drive_periods(14, 7, 4);
        check_val("recover_after4", locked, 0);
        drive_periods(14, 7, 1);
        check_val("recover_after5", locked, 1);

        // Single jittered period
        l0 = lost_seen;
        drive_periods(18, 9, 1);
        drive_periods(14, 7, 1);
        check_val("jitter_drop", locked, 0);
        drive_periods(14, 7, 3);
        check_val("jitter_after3", locked, 0);
        drive_periods(14, 7, 1);
        check_val("jitter_relock", locked, 1);
        check_val("jitter_nolost", lost_seen - l0, 0);

        // Reset while locked
        pulse_reset();
        check_val("rst_locked", locked, 0);
        check_val("rst_period", period, 0);
        check_val("rst_phase", phase, 0);
        drive_periods(14, 7, 1);
        check_val("rst_first_period", period, 0);
        drive_periods(14, 7, 6);

        // Boundary periods
        drive_periods(12, 6, 8);
        check_val("p12_locked", locked, 1);
        drive_periods(16, 8, 8);
        check_val("p16_locked", locked, 1);
        drive_periods(11, 5, 8);
        check_val("p11_locked", locked, 0);
        check_val("p11_period", period, 11);
        drive_periods(17, 8, 8);
        check_val("p17_locked", locked, 0);
        check_val("p17_period", period, 17);

        // Randomised segments with occasional loss and reset
        for (int s = 0; s < 40; s++) begin
            int p, hi, n;
            p  = $urandom_range(22, 9);
            hi = $urandom_range(p - 2, 2);
            n  = $urandom_range(8, 1);
            drive_periods(p, hi, n);
            if ($urandom_range(7, 0) == 0) repeat ($urandom_range(50, 20)) @(negedge clk);
            if ($urandom_range(11, 0) == 0) begin
                repeat (4) @(negedge clk);
                pulse_reset();
            end
        end
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
